// File: rtl/cpu_system_pkg.sv
// Shared definitions for the cpu_system datapath: ALU opcodes, branch
// condition codes and instruction-register field positions.
package cpu_system_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  typedef enum logic [1:0] {
    C2_ZERO    = 2'b00,
    C2_NONZERO = 2'b01,
    C2_POS     = 2'b10,
    C2_NEG     = 2'b11
  } cond_e;

  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;
  localparam int IR_C2_MSB = 20;
  localparam int IR_C2_LSB = 19;
  localparam int IR_C_MSB  = 18;

  // Zero counts as positive for the C2_POS test.
  function automatic logic cond_met(input logic [1:0] c2, input logic is_zero,
                                    input logic sign);
    case (cond_e'(c2))
      C2_ZERO:    return is_zero;
      C2_NONZERO: return !is_zero;
      C2_POS:     return !sign;
      default:    return sign;
    endcase
  endfunction

endpackage

// File: rtl/cpu_system_if.sv
// Register-transfer control and data signals between the sequencer and the
// cpu_system datapath.
interface cpu_system_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
  logic [DATA_WIDTH-1:0] inport_data;
  logic                  inport_data_ready;
  logic [DATA_WIDTH-1:0] outport_data;
  logic [4:0]            opcode;
  logic                  IncPC;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic Mem_Read, Mem_Write, Mem_enable512x32;
  logic                  mem_overide;
  logic [ADDR_WIDTH-1:0] overide_address;
  logic [DATA_WIDTH-1:0] overide_data_in;
  logic                  con_ff_bit;
  logic [DATA_WIDTH-1:0] Mem_to_datapath_out;
  logic [DATA_WIDTH-1:0] Mem_data_to_chip_out;
  logic [ADDR_WIDTH-1:0] MAR_address_out;
  logic                  memory_done;

  modport master (
    output HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
    output inport_data, inport_data_ready, opcode, IncPC,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output Mem_Read, Mem_Write, Mem_enable512x32,
    output mem_overide, overide_address, overide_data_in,
    input  outport_data, con_ff_bit, Mem_to_datapath_out, Mem_data_to_chip_out,
    input  MAR_address_out, memory_done
  );

  modport slave (
    input  HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
    input  inport_data, inport_data_ready, opcode, IncPC,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  Mem_Read, Mem_Write, Mem_enable512x32,
    input  mem_overide, overide_address, overide_data_in,
    output outport_data, con_ff_bit, Mem_to_datapath_out, Mem_data_to_chip_out,
    output MAR_address_out, memory_done
  );
endinterface

// File: rtl/cpu_system_ram512x32.sv
// Falling-edge word RAM with a preload override port; contents survive clear,
// only the read latch and the done flag are reset.
module ram512x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  read,
  input  logic                  write,
  input  logic                  overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(negedge Clock) begin
    if (enable) begin
      if (overide)    mem[overide_address] <= overide_data;
      else if (write) mem[address]         <= data_in;
    end
  end

  // done stays high until a falling edge sees enable low.
  always_ff @(negedge Clock or posedge clear) begin
    if (clear) begin
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      if (enable && !overide && read) data_out <= mem[address];
      if (!enable)                                done <= 1'b0;
      else if (overide || read || write)          done <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_system.sv
// Single-bus 32-bit datapath steered cycle by cycle by external register-transfer
// controls; all registers load on the rising edge from the current bus value.
module cpu_system
  import cpu_system_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic      Clock,
  input  logic      clear,
  cpu_system_if.slave bus_if
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs [16];
  logic [DATA_WIDTH-1:0] pc, y, z_hi, z_lo, hi, lo, mdr, inport_q, outport_q;
  logic [ADDR_WIDTH-1:0] mar;
  // The opcode field is decoded by the external sequencer, so IR keeps only the operand fields.
  logic [IR_RA_MSB:0]    ir;
  logic                  con_q;

  logic [DATA_WIDTH-1:0] bus, c_ext, mem_rd, alu_lo;
  logic signed [DATA_WIDTH-1:0] y_s;
  logic [4:0]            amt;
  logic [3:0]            sel;

  always_comb begin
    sel = 4'd0;
    if (bus_if.Gra)      sel = ir[IR_RA_MSB:IR_RA_LSB];
    else if (bus_if.Grb) sel = ir[IR_RB_MSB:IR_RB_LSB];
    else if (bus_if.Grc) sel = ir[IR_RC_MSB:IR_RC_LSB];
  end

  assign c_ext = {{(DATA_WIDTH-IR_C_MSB-1){ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};

  always_comb begin
    bus = '0;
    if (bus_if.Rout)            bus = regs[sel];
    else if (bus_if.BAout)      bus = (sel == 4'd0) ? '0 : regs[sel];
    else if (bus_if.PCout)      bus = pc;
    else if (bus_if.MDRout)     bus = mdr;
    else if (bus_if.Zlo_out)    bus = z_lo;
    else if (bus_if.Zhi_out)    bus = z_hi;
    else if (bus_if.HIout)      bus = hi;
    else if (bus_if.LOout)      bus = lo;
    else if (bus_if.Inport_out) bus = inport_q;
    else if (bus_if.Cout)       bus = c_ext;
  end

  // ALU: A = Y, B = bus; every defined operation leaves the upper Z word zero.
  assign y_s = y;
  assign amt = bus[4:0];

  always_comb begin
    alu_lo = '0;
    if (bus_if.IncPC) begin
      alu_lo = bus + ONE;
    end else begin
      case (bus_if.opcode)
        OP_ADD:  alu_lo = y + bus;
        OP_SUB:  alu_lo = y - bus;
        OP_AND:  alu_lo = y & bus;
        OP_OR:   alu_lo = y | bus;
        OP_SHR:  alu_lo = y >> amt;
        OP_SHRA: alu_lo = y_s >>> amt;
        OP_SHL:  alu_lo = y << amt;
        OP_ROR:  alu_lo = (y >> amt) | (y << (6'd32 - {1'b0, amt}));
        OP_ROL:  alu_lo = (y << amt) | (y >> (6'd32 - {1'b0, amt}));
        OP_NEG:  alu_lo = '0 - bus;
        OP_NOT:  alu_lo = ~bus;
        default: alu_lo = '0;
      endcase
    end
  end

  // Register transfer stage: rising-edge loads from the bus.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      pc        <= '0;
      ir        <= '0;
      y         <= '0;
      z_hi      <= '0;
      z_lo      <= '0;
      hi        <= '0;
      lo        <= '0;
      mar       <= '0;
      mdr       <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      con_q     <= 1'b0;
    end else begin
      if (bus_if.Rin)   regs[sel] <= bus;
      if (bus_if.PCin)  pc <= bus;
      if (bus_if.IRin)  ir <= bus[IR_RA_MSB:0];
      if (bus_if.Yin)   y <= bus;
      if (bus_if.Zin) begin
        z_hi <= '0;
        z_lo <= alu_lo;
      end
      if (bus_if.HIin)  hi <= bus;
      if (bus_if.LOin)  lo <= bus;
      if (bus_if.MARin) mar <= bus[ADDR_WIDTH-1:0];
      if (bus_if.MDRin) mdr <= bus_if.Mem_Read ? mem_rd : bus;
      if (bus_if.inport_data_ready) inport_q <= bus_if.inport_data;
      if (bus_if.outport_in)        outport_q <= bus;
      if (bus_if.CONin)
        con_q <= cond_met(ir[IR_C2_MSB:IR_C2_LSB], bus == '0, bus[DATA_WIDTH-1]);
    end
  end

  ram512x32 #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .Clock           (Clock),
    .clear           (clear),
    .enable          (bus_if.Mem_enable512x32),
    .read            (bus_if.Mem_Read),
    .write           (bus_if.Mem_Write),
    .overide         (bus_if.mem_overide),
    .overide_address (bus_if.overide_address),
    .overide_data    (bus_if.overide_data_in),
    .address         (mar),
    .data_in         (mdr),
    .data_out        (mem_rd),
    .done            (bus_if.memory_done)
  );

  assign bus_if.outport_data         = outport_q;
  assign bus_if.con_ff_bit           = con_q;
  assign bus_if.Mem_to_datapath_out  = mem_rd;
  assign bus_if.Mem_data_to_chip_out = mdr;
  assign bus_if.MAR_address_out      = mar;

endmodule

// File: tb/tb_cpu_system.sv
// Directed bench for cpu_system: stimulus pushes expected values into a
// scoreboard queue, a monitor compares them against the DUT outputs.
module tb_cpu_system;
  import cpu_system_pkg::*;

  localparam int K_OUT  = 0;
  localparam int K_CON  = 1;
  localparam int K_MDR  = 2;
  localparam int K_DONE = 3;
  localparam int K_MAR  = 4;
  localparam int K_MEM  = 5;

  logic Clock = 1'b0;
  logic clear = 1'b1;

  cpu_system_if bif ();
  cpu_system dut (.Clock(Clock), .clear(clear), .bus_if(bif));

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_OUT:   return bif.outport_data;
      K_CON:   return {31'b0, bif.con_ff_bit};
      K_MDR:   return bif.Mem_data_to_chip_out;
      K_DONE:  return {31'b0, bif.memory_done};
      K_MAR:   return {23'b0, bif.MAR_address_out};
      default: return bif.Mem_to_datapath_out;
    endcase
  endfunction

  // Monitor: checks everything queued, sampled 2 time units after each rising edge.
  initial begin
    chk_t        c;
    logic [31:0] a;
    forever begin
      @(posedge Clock);
      #2;
      while (sb.size() > 0) begin
        c = sb.pop_front();
        a = actual(c.kind);
        n_checks++;
        if (a === c.exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", c.name, a, c.exp);
      end
    end
  end

  task automatic idle();
    bif.HIout = 0; bif.LOout = 0; bif.Zhi_out = 0; bif.Zlo_out = 0;
    bif.PCout = 0; bif.MDRout = 0; bif.Inport_out = 0; bif.Cout = 0;
    bif.MARin = 0; bif.Zin = 0; bif.PCin = 0; bif.MDRin = 0; bif.IRin = 0;
    bif.Yin = 0; bif.HIin = 0; bif.LOin = 0; bif.CONin = 0; bif.outport_in = 0;
    bif.inport_data_ready = 0; bif.opcode = 5'b0; bif.IncPC = 0;
    bif.Gra = 0; bif.Grb = 0; bif.Grc = 0; bif.Rin = 0; bif.Rout = 0; bif.BAout = 0;
    bif.Mem_Read = 0; bif.Mem_Write = 0; bif.Mem_enable512x32 = 0; bif.mem_overide = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic expect_v(input string n, input int k, input logic [31:0] v);
    chk_t c;
    c.name = n; c.kind = k; c.exp = v;
    sb.push_back(c);
  endtask

  // Caller selects the bus source; this captures it into the output port.
  task automatic observe(input string n, input logic [31:0] v);
    bif.outport_in = 1;
    tick();
    expect_v(n, K_OUT, v);
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    bif.mem_overide = 1; bif.Mem_enable512x32 = 1;
    bif.overide_address = a; bif.overide_data_in = d;
    tick();
  endtask

  task automatic set_inport(input logic [31:0] v);
    bif.inport_data = v; bif.inport_data_ready = 1;
    tick();
  endtask

  task automatic fetch();
    bif.PCout = 1; bif.MARin = 1; bif.IncPC = 1; bif.Zin = 1;
    tick();
    bif.Zlo_out = 1; bif.PCin = 1; bif.Mem_Read = 1; bif.MDRin = 1; bif.Mem_enable512x32 = 1;
    tick();
    bif.MDRout = 1; bif.IRin = 1;
    tick();
  endtask

  task automatic branch(input string n, input logic exp_con,
                        input logic [31:0] exp_z, input logic [31:0] exp_pc);
    fetch();
    bif.Gra = 1; bif.Rout = 1; bif.CONin = 1;
    tick();
    expect_v({n, "_con"}, K_CON, {31'b0, exp_con});
    bif.PCout = 1; bif.Yin = 1;
    tick();
    bif.Cout = 1; bif.Zin = 1; bif.opcode = OP_ADD;
    tick();
    bif.Zlo_out = 1; observe({n, "_z"}, exp_z);
    if (exp_con) begin
      bif.Zlo_out = 1; bif.PCin = 1;
      tick();
    end
    bif.PCout = 1; observe({n, "_pc"}, exp_pc);
  endtask

  task automatic con_test(input string n, input logic exp_con);
    bif.Gra = 1; bif.Rout = 1; bif.CONin = 1;
    tick();
    expect_v(n, K_CON, {31'b0, exp_con});
  endtask

  task automatic load_r5(input logic [31:0] v);
    set_inport(v);
    bif.Inport_out = 1; bif.Gra = 1; bif.Rin = 1;
    tick();
  endtask

  task automatic load_ir(input logic [31:0] v);
    set_inport(v);
    bif.Inport_out = 1; bif.IRin = 1;
    tick();
  endtask

  task automatic alu_case(input string n, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    set_inport(a);
    bif.Inport_out = 1; bif.Yin = 1;
    tick();
    set_inport(b);
    bif.Inport_out = 1; bif.Zin = 1; bif.opcode = op;
    tick();
    bif.Zlo_out = 1; observe(n, exp);
  endtask

  initial begin
    idle();
    bif.inport_data = '0; bif.overide_address = '0; bif.overide_data_in = '0;
    clear = 1'b1;
    @(posedge Clock);
    #1;
    expect_v("rst_out", K_OUT, 32'h0);
    expect_v("rst_con", K_CON, 32'h0);
    expect_v("rst_mdr", K_MDR, 32'h0);
    expect_v("rst_mar", K_MAR, 32'h0);
    expect_v("rst_mem", K_MEM, 32'h0);
    expect_v("rst_done", K_DONE, 32'h0);
    clear = 1'b0;
    bif.PCout = 1; observe("rst_pc", 32'h0);

    preload(9'd0,  32'h0A800000);
    preload(9'd1,  32'h9A80000E);
    preload(9'd16, 32'h9A88000E);
    preload(9'd17, 32'h9A90000E);
    preload(9'd32, 32'h9A98000E);

    // Direct read of address 0, MAR still at its reset value.
    bif.Mem_Read = 1; bif.MDRin = 1; bif.Mem_enable512x32 = 1;
    tick();
    expect_v("rd0_mdr", K_MDR, 32'h0A800000);
    expect_v("rd0_done", K_DONE, 32'h1);
    tick();
    expect_v("rd0_done_clr", K_DONE, 32'h0);

    // ldi r5,0
    fetch();
    bif.Grb = 1; bif.BAout = 1; bif.Yin = 1;
    tick();
    bif.Cout = 1; bif.Zin = 1; bif.opcode = OP_ADD;
    tick();
    bif.Zlo_out = 1; bif.Gra = 1; bif.Rin = 1;
    tick();
    bif.Gra = 1; bif.Rout = 1; observe("ldi_r5", 32'h0);
    bif.PCout = 1; observe("ldi_pc", 32'h1);

    branch("brzr", 1'b1, 32'd16, 32'd16);
    branch("brnz", 1'b0, 32'd31, 32'd17);
    branch("brpl", 1'b1, 32'd32, 32'd32);
    branch("brmi", 1'b0, 32'd47, 32'd33);

    load_r5(32'hFFFFFFFD);
    con_test("neg3_brmi", 1'b1);
    load_ir(32'h9A90000E);
    con_test("neg3_brpl", 1'b0);
    load_r5(32'h00000003);
    load_ir(32'h9A88000E);
    con_test("pos3_brnz", 1'b1);
    bif.Gra = 1; bif.Rout = 1; observe("r5_eq3", 32'h3);

    // Bus resolution: register source beats PC, idle bus is zero, BAout masks R0.
    bif.Gra = 1; bif.Rout = 1; bif.PCout = 1; observe("prio_rout_pc", 32'h3);
    observe("bus_idle", 32'h0);
    set_inport(32'h00000055);
    bif.Inport_out = 1; bif.Rin = 1;
    tick();
    bif.Rout = 1; observe("r0_rout", 32'h55);
    bif.BAout = 1; observe("r0_baout", 32'h0);

    alu_case("alu_add",  OP_ADD,  32'h00000005, 32'h00000007, 32'h0000000C);
    bif.Zhi_out = 1; observe("alu_add_hi", 32'h0);
    alu_case("alu_sub",  OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE);
    alu_case("alu_and",  OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    alu_case("alu_or",   OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
    alu_case("alu_shr",  OP_SHR,  32'h80000010, 32'h00000004, 32'h08000001);
    alu_case("alu_shra", OP_SHRA, 32'h80000010, 32'h00000004, 32'hF8000001);
    alu_case("alu_shl",  OP_SHL,  32'h80000010, 32'h00000004, 32'h00000100);
    alu_case("alu_ror",  OP_ROR,  32'h80000013, 32'h00000004, 32'h38000001);
    alu_case("alu_rol",  OP_ROL,  32'h80000013, 32'h00000004, 32'h00000138);
    alu_case("alu_neg",  OP_NEG,  32'h00000000, 32'h00000005, 32'hFFFFFFFB);
    alu_case("alu_not",  OP_NOT,  32'h00000000, 32'h0F0F0F0F, 32'hF0F0F0F0);
    alu_case("alu_bad",  5'b00000, 32'h00000005, 32'h00000007, 32'h00000000);

    // Datapath write to RAM[5] then read back.
    set_inport(32'h12345678);
    bif.Inport_out = 1; bif.MDRin = 1;
    tick();
    set_inport(32'h00000005);
    bif.Inport_out = 1; bif.MARin = 1;
    tick();
    expect_v("wr_mar", K_MAR, 32'h5);
    expect_v("wr_mdr", K_MDR, 32'h12345678);
    bif.Mem_Write = 1; bif.Mem_enable512x32 = 1;
    tick();
    bif.Mem_Read = 1; bif.MDRin = 1; bif.Mem_enable512x32 = 1;
    tick();
    expect_v("rd5_mem", K_MEM, 32'h12345678);
    expect_v("rd5_done", K_DONE, 32'h1);

    // Clear in the middle of an ALU op with CON set and MAR/MDR non-zero.
    load_r5(32'h00000000);
    load_r5(32'h00000003);
    con_test("pre_clear_con", 1'b1);
    set_inport(32'h00000007);
    bif.Inport_out = 1; bif.Yin = 1;
    tick();
    bif.Inport_out = 1; bif.Zin = 1; bif.opcode = OP_ADD; bif.PCin = 1;
    clear = 1'b1;
    expect_v("clr_con", K_CON, 32'h0);
    expect_v("clr_mar", K_MAR, 32'h0);
    expect_v("clr_mdr", K_MDR, 32'h0);
    expect_v("clr_mem", K_MEM, 32'h0);
    tick();
    clear = 1'b0;
    bif.PCout = 1; observe("clr_pc", 32'h0);
    bif.Zlo_out = 1; observe("clr_z", 32'h0);
    bif.Mem_Read = 1; bif.MDRin = 1; bif.Mem_enable512x32 = 1;
    tick();
    expect_v("ram_kept", K_MEM, 32'h0A800000);
    expect_v("ram_kept_mdr", K_MDR, 32'h0A800000);

    repeat (3) @(posedge Clock);
    #3;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard: %0d checks left unmatched, expected 0", sb.size());
      n_checks += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
